// File: rtl/ucomb_cfg_pkg.sv
// Shared types and constants for the ucomb configuration loader.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package ucomb_cfg_pkg;

   localparam int CFG_W_DEF = 23;
   localparam int ADDR_W    = 7;

   localparam logic [CFG_W_DEF-1:0] CFG_ZERO = '0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2,
      ST_WRITE  = 2'd3
   } state_t;

endpackage

// File: rtl/ucomb_cfg_shreg.sv
// Shadow shift register (MSB first) with bit counter and running parity.
// Latency: a shifted bit is visible in word the cycle after shift_en.
// Backpressure: none; the caller gates shift_en. Parity port exists with UCOMB_CFG_PARITY_EN.
module ucomb_cfg_shreg
   import ucomb_cfg_pkg::*;
#(
   parameter int CFG_W = CFG_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             bit_in,
   output logic [CFG_W-1:0] word,
`ifdef UCOMB_CFG_PARITY_EN
   output logic             par,
`endif
   output logic             last
);

   localparam int CNT_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;

   logic [CNT_W-1:0] cnt;

   assign last = (cnt == CNT_W'(CFG_W - 1));

   // Shift accepted bits in from the right; counter wraps after the last bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         word <= '0;
         cnt  <= '0;
      end else if (clr) begin
         cnt  <= '0;
      end else if (shift_en) begin
         word <= {word[CFG_W-2:0], bit_in};
         cnt  <= last ? '0 : cnt + 1'b1;
      end
   end

`ifdef UCOMB_CFG_PARITY_EN
   // Running XOR of the bits shifted in since the load started.
   always_ff @(posedge clk) begin
      if (rst || clr) par <= 1'b0;
      else if (shift_en) par <= par ^ bit_in;
   end
`endif

endmodule

// File: rtl/ucomb_cfg_loader.sv
// Serial config loader: assembles a word per cell into staging, commits staging to live atomically.
// Latency: start -> done = CFG_W+2 cycles gap-free (+1 with UCOMB_CFG_PARITY_EN); commit -> cfg_out 1 cycle.
// Backpressure: bit_ready high in SHIFT/PARITY only; bubbles on bit_valid stall the load indefinitely.
module ucomb_cfg_loader
   import ucomb_cfg_pkg::*;
#(
   parameter int NUM_CELLS = 8,
   parameter int CFG_W     = CFG_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [ADDR_W-1:0]          addr,
   input  logic                       bit_valid,
   input  logic                       bit_in,
   output logic                       bit_ready,
   input  logic                       abort,
   input  logic                       commit,
   output logic [NUM_CELLS*CFG_W-1:0] cfg_out,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   localparam int                BANK_W      = NUM_CELLS * CFG_W;
   localparam logic [ADDR_W:0]   NUM_CELLS_V = (ADDR_W + 1)'(NUM_CELLS);

   state_t              state;
   logic [ADDR_W-1:0]   addr_q;
   logic [CFG_W-1:0]    word;
   logic                last;
   logic                accept;
   logic                addr_ok;
   logic [BANK_W-1:0]   staging;
   logic [BANK_W-1:0]   staging_nxt;
`ifdef UCOMB_CFG_PARITY_EN
   logic                par;
`endif

   assign accept  = bit_valid & bit_ready & ~abort;
   assign addr_ok = ({1'b0, addr} < NUM_CELLS_V);

   ucomb_cfg_shreg #(.CFG_W(CFG_W)) u_shreg (
      .clk      (clk),
      .rst      (rst),
      .clr      ((state == ST_IDLE) & start),
      .shift_en (accept & (state == ST_SHIFT)),
      .bit_in   (bit_in),
      .word     (word),
`ifdef UCOMB_CFG_PARITY_EN
      .par      (par),
`endif
      .last     (last)
   );

   // Load sequencing; busy/bit_ready/done/err are registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         busy      <= 1'b0;
         bit_ready <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (addr_ok) begin
                     state     <= ST_SHIFT;
                     addr_q    <= addr;
                     busy      <= 1'b1;
                     bit_ready <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               if (abort) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  bit_ready <= 1'b0;
               end else if (accept && last) begin
`ifdef UCOMB_CFG_PARITY_EN
                  state     <= ST_PARITY;
`else
                  state     <= ST_WRITE;
                  bit_ready <= 1'b0;
`endif
               end
            end
`ifdef UCOMB_CFG_PARITY_EN
            ST_PARITY: begin
               if (abort) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  bit_ready <= 1'b0;
               end else if (accept) begin
                  bit_ready <= 1'b0;
                  if (par ^ bit_in) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     err   <= 1'b1;
                  end else begin
                     state <= ST_WRITE;
                  end
               end
            end
`endif
            ST_WRITE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               busy      <= 1'b0;
               bit_ready <= 1'b0;
            end
         endcase
      end
   end

   // Staging with the WRITE-cycle word merged in, so a coinciding commit writes through.
   always_comb begin
      staging_nxt = staging;
      if (state == ST_WRITE) staging_nxt[int'(addr_q)*CFG_W +: CFG_W] = word;
   end

   // Staging bank update and atomic copy to the live bank on commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         staging <= '0;
         cfg_out <= '0;
      end else begin
         staging <= staging_nxt;
         if (commit) cfg_out <= staging_nxt;
      end
   end

endmodule

// File: tb/tb_ucomb_cfg_loader.sv
// Self-checking bench for ucomb_cfg_loader (honours UCOMB_CFG_PARITY_EN when defined).
// Latency: n/a.
// Backpressure: bubbles on bit_valid are injected randomly.
module tb_ucomb_cfg_loader;

   localparam int NC = 8;
   localparam int CW = 23;
`ifdef UCOMB_CFG_PARITY_EN
   localparam int PAR_EXTRA = 1;
`else
   localparam int PAR_EXTRA = 0;
`endif

   logic             clk = 1'b0;
   logic             rst, start, bit_valid, bit_in, abort, commit;
   logic [6:0]       addr;
   logic             bit_ready, busy, done, err;
   logic [NC*CW-1:0] cfg_out;

   int n_tests = 0;
   int n_fail  = 0;

   logic [CW-1:0] stage [NC];
   logic [CW-1:0] live  [NC];

   always #5 clk = ~clk;

   ucomb_cfg_loader #(.NUM_CELLS(NC), .CFG_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .addr(addr), .bit_valid(bit_valid),
      .bit_in(bit_in), .bit_ready(bit_ready), .abort(abort), .commit(commit),
      .cfg_out(cfg_out), .busy(busy), .done(done), .err(err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [NC*CW-1:0] act, input logic [NC*CW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [NC*CW-1:0] pack_live();
      logic [NC*CW-1:0] v;
      for (int k = 0; k < NC; k++) v[k*CW +: CW] = live[k];
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NC; k++) begin
         stage[k] = '0;
         live[k]  = '0;
      end
   endtask

   task automatic do_commit();
      commit = 1'b1;
      tick();
      commit = 1'b0;
      for (int k = 0; k < NC; k++) live[k] = stage[k];
   endtask

   // Drives one load; stray starts during the load must be ignored by the DUT.
   task automatic run_load(input int a, input logic [CW-1:0] w, input int gap_pct, input int abort_at,
                           input bit cw, input bit par_bad,
                           output bit got_done, output bit got_err, output int lat);
      got_done = 0; got_err = 0; lat = 0;
      addr = 7'(a); start = 1'b1;
      tick(); lat++;
      start = 1'b0;
      if (err) got_err = 1;
      if (!busy) return;
      for (int i = 0; i < CW; i++) begin
         if (i == abort_at) begin
            start = 1'b0; bit_valid = 1'b0; abort = 1'b1;
            tick(); lat++;
            abort = 1'b0;
            if (err) got_err = 1;
            return;
         end
         for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
            bit_valid = 1'b0;
            tick(); lat++;
         end
         start = 1'($urandom_range(1));
         addr  = 7'($urandom_range(NC - 1));
         bit_valid = 1'b1;
         bit_in = w[CW-1-i];
         tick(); lat++;
      end
      start = 1'b0;
`ifdef UCOMB_CFG_PARITY_EN
      bit_valid = 1'b1;
      bit_in = (^w) ^ par_bad;
      tick(); lat++;
      if (err) begin
         got_err = 1;
         bit_valid = 1'b0;
         return;
      end
`endif
      bit_valid = 1'b0;
      commit = cw;
      for (int k = 0; k < 4; k++) begin
         tick(); lat++;
         commit = 1'b0;
         if (done) got_done = 1;
         if (err)  got_err  = 1;
         if (done || err) break;
      end
   endtask

   task automatic step(input string name, input int a, input logic [CW-1:0] w, input int gap_pct,
                       input int abort_at, input bit cw, input bit post, input bit par_bad,
                       input bit exp_done, input bit exp_err);
      bit gd, ge;
      int lat;
      run_load(a, w, gap_pct, abort_at, cw, par_bad, gd, ge, lat);
      chk({name, " done"}, NC*CW'(gd), NC*CW'(exp_done));
      chk({name, " err"},  NC*CW'(ge), NC*CW'(exp_err));
      chk({name, " busy idle"}, NC*CW'(busy), '0);
      if (exp_done && gap_pct == 0 && abort_at < 0)
         chk({name, " latency"}, NC*CW'(lat), NC*CW'(CW + 2 + PAR_EXTRA));
      if (exp_done) begin
         stage[a] = w;
         if (cw) for (int k = 0; k < NC; k++) live[k] = stage[k];
      end
      if (post) do_commit();
      chk({name, " cfg_out"}, cfg_out, pack_live());
   endtask

   typedef struct {
      int            a;
      logic [CW-1:0] w;
      bit            cw;
      bit            post;
      bit            exp_done;
      bit            exp_err;
      logic [CW-1:0] exp_live;
   } vec_t;

   vec_t vecs [5];

   initial begin
      rst = 1'b1; start = 0; addr = 0; bit_valid = 0; bit_in = 0; abort = 0; commit = 0;
      model_reset();
      vecs[0] = '{0, 23'h4C0004, 1'b0, 1'b1, 1'b1, 1'b0, 23'h4C0004};
      vecs[1] = '{3, 23'h000001, 1'b0, 1'b0, 1'b1, 1'b0, 23'h000000};
      vecs[2] = '{3, 23'h000001, 1'b0, 1'b1, 1'b1, 1'b0, 23'h000001};
      vecs[3] = '{9, 23'h2AAAAA, 1'b0, 1'b1, 1'b0, 1'b1, 23'h000000};
      vecs[4] = '{2, 23'h123456, 1'b1, 1'b0, 1'b1, 1'b0, 23'h123456};

      repeat (3) tick();
      rst = 1'b0;
      chk("reset cfg_out", cfg_out, '0);
      chk("reset flags", NC*CW'({busy, done, err, bit_ready}), '0);

      for (int i = 0; i < 5; i++) begin
         step($sformatf("vec%0d", i), vecs[i].a, vecs[i].w, 0, -1, vecs[i].cw, vecs[i].post, 1'b0,
              vecs[i].exp_done, vecs[i].exp_err);
         if (vecs[i].a < NC)
            chk($sformatf("vec%0d cell", i), NC*CW'(cfg_out[vecs[i].a*CW +: CW]), NC*CW'(vecs[i].exp_live));
      end

      step("abort", 5, 23'h155555, 0, 10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step("after abort", 1, 23'h7FFFFF, 0, -1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("cell1 full", NC*CW'(cfg_out[1*CW +: CW]), NC*CW'(23'h7FFFFF));
      chk("cell5 untouched", NC*CW'(cfg_out[5*CW +: CW]), '0);

`ifdef UCOMB_CFG_PARITY_EN
      step("parity bad", 6, 23'h4C0004, 0, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step("parity good", 6, 23'h4C0004, 0, -1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`endif

      for (int r = 0; r < 40; r++) begin
         int a, ab;
         bit pb, ed, ee;
         logic [CW-1:0] w;
         a  = int'($urandom_range(NC + 2));
         w  = CW'($urandom);
         ab = ($urandom_range(7) == 0) ? int'($urandom_range(CW - 1)) : -1;
`ifdef UCOMB_CFG_PARITY_EN
         pb = ($urandom_range(4) == 0);
`else
         pb = 1'b0;
`endif
         ed = (a < NC) && (ab < 0) && !pb;
         ee = (a >= NC) || ((a < NC) && (ab < 0) && pb);
         step($sformatf("rnd%0d", r), a, w, int'($urandom_range(40)), ab,
              1'($urandom_range(1)), ($urandom_range(2) == 0), pb, ed, ee);
      end

      // Reset in the middle of a shift clears live and staging banks.
      addr = 7'd4; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bit_valid = 1'b1; bit_in = 1'b1;
         tick();
      end
      bit_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      chk("rst mid cfg_out", cfg_out, '0);
      chk("rst mid flags", NC*CW'({busy, done, err, bit_ready}), '0);
      tick();
      chk("rst idle flags", NC*CW'({busy, done, err, bit_ready}), '0);
      do_commit();
      chk("rst staging", cfg_out, pack_live());

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ucomb_cfg_loader.md
# ucomb_cfg_loader

Serial configuration loader and commit controller for an array of `ucomb_full` universal gate cells. It accepts a cell address and a 23-bit configuration word as a handshaked bit stream, and assembles the word in a shift register. It then writes the word into a per-cell staging bank and, on a commit request, copies the whole staging bank into the live configuration bus at once. This lets the gate fabric change function without partially-configured intermediate states.

## Interface
- `NUM_CELLS`, default 8: number of `ucomb_full` cells served; legal range 1–128.
- `CFG_W`, default 23: configuration bits per cell; matches the `ucomb_full` config field.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin load of one cell; sampled only in IDLE.
- `addr`  in  7  target cell index; sampled with `start`.
- `bit_valid`  in  1  serial bit present.
- `bit_in`  in  1  serial config bit; MSB first.
- `bit_ready`  out  1  loader accepts a bit this cycle.
- `abort`  in  1  discard the in-progress load.
- `commit`  in  1  copy staging bank to live bank.
- `cfg_out`  out  NUM_CELLS*CFG_W  live configuration; cell k is at `[k*CFG_W +: CFG_W]`.
- `busy`  out  1  FSM not in IDLE.
- `done`  out  1  one-cycle pulse: a word has been written to staging.
- `err`  out  1  one-cycle pulse: bad address or parity failure.

## Operation
- FSM states and transitions:
  - IDLE → SHIFT on `start` with `addr < NUM_CELLS`.
  - `start` with `addr >= NUM_CELLS` stays in IDLE and pulses `err` next cycle.
  - SHIFT → (PARITY | WRITE) after the CFG_W-th accepted bit.
  - PARITY → WRITE on a good parity bit; PARITY → IDLE with `err` on a bad one.
  - WRITE → IDLE, always after one cycle.
- `bit_ready` = 1 in SHIFT and PARITY only. A bit transfers when `bit_valid & bit_ready`. Bits shift left into the shadow register. The bit counter counts 0..CFG_W-1.
- WRITE writes the shadow register to `staging[addr_q]` and pulses `done` in the following cycle.
- `commit` (any state): `cfg_out <= staging`. If `commit` coincides with the WRITE cycle, the word being written is included in the live bank (write-through).
- `abort` in SHIFT or PARITY returns to IDLE with no staging write and no `err`. `abort` in IDLE or WRITE is ignored, so WRITE still completes.
- `start` while busy: ignored, not queued.
- Reset values:
  - `cfg_out`, staging and shadow: all 0.
  - `busy`, `done`, `err`, `bit_ready`: 0.
  - FSM: IDLE.
- A reset mid-load clears everything, including the live bank.

## Timing
- Load latency with zero bubbles: 1 cycle (IDLE→SHIFT) + CFG_W bit cycles (+1 for parity) + 1 WRITE cycle. `done` appears the cycle after WRITE.
- With default parameters and parity off, `done` asserts 25 cycles after `start`.
- Bubbles (`bit_valid` = 0) stall the counter. There is no timeout.
- `cfg_out` changes only on the edge after `commit`; it is never touched by loads alone.
- `done` and `err` are registered and mutually exclusive.

## Configuration
- `UCOMB_CFG_PARITY_EN` defined:
  - The PARITY state exists; one extra bit follows the word.
  - The total count of ones over word plus parity bit must be even; otherwise `err` is pulsed and staging is unchanged.
- Macro undefined: no PARITY state; SHIFT goes directly to WRITE; `err` is raised only for a bad address.

## Structure
- Package `ucomb_cfg_pkg`:
  - `CFG_W` default constant.
  - FSM state enum (IDLE, SHIFT, PARITY, WRITE).
  - Address width constant (7).
  - All-zero default config word.
- Sub-module `ucomb_cfg_shreg`: CFG_W-bit shadow shift register plus bit counter, with `last` and running parity outputs.
- The top level holds the FSM, the staging bank and the live bank.

## Test plan
- Load cell 0 with 23'h4C0004, gap-free, parity off, then `commit` → `done` 25 cycles after `start`; `cfg_out[22:0]` = 23'h4C0004; other cells 0.
- Load cell 3 with 23'h000001, no commit → `cfg_out` stays all-zero; after `commit`, `cfg_out[91:69]` = 23'h000001.
- `start` with `addr` = 9 (NUM_CELLS = 8) → `err` pulse, `busy` stays 0, staging unchanged.
- `abort` after 10 bits, then a full load of cell 1 with 23'h7FFFFF → only cell 1 holds 23'h7FFFFF after commit; no `err`.
- Parity on, word 23'h4C0004 (four ones) with parity bit 1 → `err`, no `done`; the same word with parity 0 → `done`.
- `commit` asserted in the WRITE cycle of cell 2 = 23'h123456 → `cfg_out[68:46]` = 23'h123456 on the next edge; `rst` mid-SHIFT → all outputs 0, IDLE.
